fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined `mips` core. It sits directly upstream of the decode/execute datapath. It owns the PC and drives a synchronous-read instruction memory with 1-cycle latency. Fetched words land in a 2-entry output buffer, which feeds decode through a valid/ready handshake; branch/jump redirects from downstream flush the stage.

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory and buffers fetched words in a 2-entry FIFO toward decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    always_comb begin
        id_valid  = (count != 2'd0) & ~redirect_valid;
        pop       = id_valid & id_ready;
        push      = inflight & ~redirect_valid;
        // Slots committed once this cycle settles: buffered + in flight - leaving.
        occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue     = reset & ~redirect_valid & (occupancy < 3'd2);
        imem_req  = issue;
        imem_addr = pc;
        id_instr  = buf_instr[rd_ptr];
        id_pc     = buf_pc[rd_ptr];
        id_pc4    = buf_pc[rd_ptr] + 32'd4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~32'd3;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= inflight_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a synchronous memory model feeds two DUTs
// (default and wrapping RESET_PC); deliveries are checked against a queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic        id_valid, id_valid_w;
    logic [31:0] id_instr, id_instr_w;
    logic [31:0] id_pc, id_pc_w;
    logic [31:0] id_pc4, id_pc4_w;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb   [$];
    logic [31:0] sb_w [$];
    bit          mon_en   = 1'b0;
    bit          mon_w_en = 1'b0;
    logic [31:0] e_m, e_w;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid_w), .id_ready(id_ready),
        .id_instr(id_instr_w), .id_pc(id_pc_w), .id_pc4(id_pc4_w)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory returns garbage when no request was made, so stray pushes show up.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? word(imem_addr)   : 32'hBAD0_BAD0;
        imem_rdata_w <= imem_req_w ? word(imem_addr_w) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && id_valid === 1'b1 && id_ready === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_extra: observed id_pc %h expected no delivery", id_pc);
            end
            if (sb.size() != 0) begin
                e_m = sb.pop_front();
                chk("deliv_pc", id_pc, e_m);
                chk("deliv_instr", id_instr, word(e_m));
                chk("deliv_pc4", id_pc4, e_m + 32'd4);
            end
        end
        if (mon_w_en && id_valid_w === 1'b1 && id_ready === 1'b1) begin
            n_cmp++;
            assert (sb_w.size() != 0) else begin
                n_err++;
                $error("FAIL sbw_extra: observed id_pc %h expected no delivery", id_pc_w);
            end
            if (sb_w.size() != 0) begin
                e_w = sb_w.pop_front();
                chk("wrap_pc", id_pc_w, e_w);
                chk("wrap_instr", id_instr_w, word(e_w));
                chk("wrap_pc4", id_pc4_w, e_w + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Reset state
        repeat (2) step();
        #1;
        chk1("rst_id_valid", id_valid, 1'b0);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h4);
        chk("rst_imem_addr", imem_addr, 32'h0000_3000);
        chk("rst_imem_addr_w", imem_addr_w, 32'hFFFF_FFF8);

        // Streaming with id_ready=1 on both DUTs
        step();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(32'h0000_3000 + 32'(4 * k));
            sb_w.push_back(32'hFFFF_FFF8 + 32'(4 * k));
        end
        mon_en   = 1'b1;
        mon_w_en = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            if (c > 0) #1;
            chk1("stream_req", imem_req, 1'b1);
            chk("stream_addr", imem_addr, 32'h0000_3000 + 32'(4 * c));
            chk1("stream_valid", id_valid, c >= 2);
        end

        // Mid-stream asynchronous reset between edges
        step();
        mon_en   = 1'b0;
        mon_w_en = 1'b0;
        #1;
        chk("stream_left", 32'(sb.size()), 32'd0);
        chk("wrap_left", 32'(sb_w.size()), 32'd0);
        chk1("pre_arst_valid", id_valid, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk1("arst_valid", id_valid, 1'b0);
        chk1("arst_req", imem_req, 1'b0);
        chk("arst_id_pc", id_pc, 32'h0);
        sb.delete();
        sb_w.delete();

        // Backpressure from reset
        id_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk1("bp_req0", imem_req, 1'b1);
        chk("bp_addr0", imem_addr, 32'h0000_3000);
        step(); #1;
        chk1("bp_req1", imem_req, 1'b1);
        chk("bp_addr1", imem_addr, 32'h0000_3004);
        chk1("bp_valid1", id_valid, 1'b0);
        for (int c = 2; c < 6; c++) begin
            step(); #1;
            chk1("bp_req_hold", imem_req, 1'b0);
            chk1("bp_valid_hold", id_valid, 1'b1);
            chk("bp_head_pc", id_pc, 32'h0000_3000);
            chk("bp_head_instr", id_instr, word(32'h0000_3000));
        end
        step();
        id_ready = 1'b1;
        sb.push_back(32'h0000_3000);
        sb.push_back(32'h0000_3004);
        sb.push_back(32'h0000_3008);
        mon_en = 1'b1;
        #1;
        chk1("bp_drain_v0", id_valid, 1'b1);
        step(); #1;
        chk1("bp_drain_v1", id_valid, 1'b1);
        step(); #1;
        chk1("bp_drain_v2", id_valid, 1'b1);
        step();
        id_ready = 1'b0;
        mon_en   = 1'b0;
        #1;
        chk("bp_left", 32'(sb.size()), 32'd0);

        // FIFO full, redirect to 0x3100
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        #1;
        chk1("full_valid", id_valid, 1'b1);
        chk1("full_req", imem_req, 1'b0);
        chk("full_head", id_pc, 32'h0000_3000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3100;
        id_ready       = 1'b1;
        sb.push_back(32'h0000_3100);
        sb.push_back(32'h0000_3104);
        mon_en = 1'b1;
        #1;
        chk1("redir_t_valid", id_valid, 1'b0);
        chk1("redir_t_req", imem_req, 1'b0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk1("redir_t1_valid", id_valid, 1'b0);
        chk1("redir_t1_req", imem_req, 1'b1);
        chk("redir_t1_addr", imem_addr, 32'h0000_3100);
        step(); #1;
        chk1("redir_t2_valid", id_valid, 1'b0);
        chk("redir_t2_addr", imem_addr, 32'h0000_3104);
        step(); #1;
        chk1("redir_t3_valid", id_valid, 1'b1);
        step(); #1;
        step();
        id_ready = 1'b0;
        mon_en   = 1'b0;
        #1;
        chk("redir_left", 32'(sb.size()), 32'd0);

        // Back-to-back redirects; last target is unaligned
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        #1;
        chk1("b2b_u_valid", id_valid, 1'b0);
        chk1("b2b_u_req", imem_req, 1'b0);
        step();
        redirect_pc = 32'h0000_3103;
        #1;
        chk1("b2b_u1_valid", id_valid, 1'b0);
        chk1("b2b_u1_req", imem_req, 1'b0);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        sb.push_back(32'h0000_3100);
        sb.push_back(32'h0000_3104);
        mon_en = 1'b1;
        #1;
        chk1("b2b_u2_req", imem_req, 1'b1);
        chk("b2b_u2_addr", imem_addr, 32'h0000_3100);
        chk1("b2b_u2_valid", id_valid, 1'b0);
        step(); #1;
        chk1("b2b_u3_valid", id_valid, 1'b0);
        chk("b2b_u3_addr", imem_addr, 32'h0000_3104);
        step(); #1;
        chk1("b2b_u4_valid", id_valid, 1'b1);
        step(); #1;
        step();
        id_ready = 1'b0;
        mon_en   = 1'b0;
        #1;
        chk("b2b_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
